// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART tx core among NUM_REQ byte producers.
// Define UART_ARB_TAG_EN to send a 0xF0|id tag byte whenever the source changes.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int BUSY_TO = 64,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = $clog2(BUSY_TO + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic [IW-1:0]        grant_id,
  output logic                 busy,
  output logic                 err_timeout
);
`ifdef UART_ARB_TAG_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_START, S_WAIT_HI, S_WAIT_LO, S_TAG_START, S_TAG_WAIT_HI, S_TAG_WAIT_LO
  } state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_START, S_WAIT_HI, S_WAIT_LO} state_t;
`endif
  state_t r_state, w_nxt;
  logic [NUM_REQ-1:0] r_ready, w_ready;
  logic [7:0] r_data, w_data, r_hold, w_hold, w_sel;
  logic r_start, w_start, r_busy, r_err, w_err, w_found;
  logic [IW-1:0] r_grant, w_grant, r_ptr, w_ptr, w_win, w_idx;
  logic [CW-1:0] r_cnt, w_cnt;
`ifdef UART_ARB_TAG_EN
  logic [IW-1:0] r_tag_id, w_tag_id;
  logic r_tag_vld, w_tag_vld;
`endif
  assign req_ready = r_ready;
  assign tx_data = r_data;
  assign tx_start = r_start;
  assign grant_id = r_grant;
  assign busy = r_busy;
  assign err_timeout = r_err;
  assign w_sel = req_data[{r_grant, 3'b000} +: 8];
  // first valid requester at or after the pointer, wrapping
  always_comb begin
    w_found = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = IW'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win = w_idx;
      end
    end
  end
  always_comb begin
    w_nxt = r_state;
    w_ready = '0;
    w_start = 1'b0;
    w_data = r_data;
    w_hold = r_hold;
    w_ptr = r_ptr;
    w_grant = r_grant;
    w_cnt = r_cnt;
    w_err = r_err;
`ifdef UART_ARB_TAG_EN
    w_tag_id = r_tag_id;
    w_tag_vld = r_tag_vld;
`endif
    case (r_state)
      S_IDLE: if (w_found) begin
        w_nxt = S_LATCH;
        w_grant = w_win;
        w_ready = NUM_REQ'(1) << w_win;
      end
      S_LATCH: begin
        w_hold = w_sel;
        w_ptr = (r_grant == IW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
        w_start = 1'b1;
`ifdef UART_ARB_TAG_EN
        w_nxt = (!r_tag_vld || r_tag_id != r_grant) ? S_TAG_START : S_START;
        w_data = (!r_tag_vld || r_tag_id != r_grant) ? (8'hF0 | 8'(r_grant)) : w_sel;
`else
        w_nxt = S_START;
        w_data = w_sel;
`endif
      end
      S_START: begin
        w_nxt = S_WAIT_HI;
        w_cnt = '0;
      end
      S_WAIT_HI: begin
        if (tx_busy) w_nxt = S_WAIT_LO;
        else if (r_cnt == CW'(BUSY_TO - 1)) begin
          w_err = 1'b1;
          w_nxt = S_IDLE;
        end else w_cnt = r_cnt + 1'b1;
      end
      S_WAIT_LO: w_nxt = tx_busy ? S_WAIT_LO : S_IDLE;
`ifdef UART_ARB_TAG_EN
      S_TAG_START: begin
        w_nxt = S_TAG_WAIT_HI;
        w_cnt = '0;
      end
      // a tag timeout drops the held data byte as well
      S_TAG_WAIT_HI: begin
        if (tx_busy) w_nxt = S_TAG_WAIT_LO;
        else if (r_cnt == CW'(BUSY_TO - 1)) begin
          w_err = 1'b1;
          w_nxt = S_IDLE;
        end else w_cnt = r_cnt + 1'b1;
      end
      S_TAG_WAIT_LO: if (!tx_busy) begin
        w_nxt = S_START;
        w_start = 1'b1;
        w_data = r_hold;
        w_tag_id = r_grant;
        w_tag_vld = 1'b1;
      end
`endif
      default: w_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ready <= '0;
      r_start <= 1'b0;
      r_data <= '0;
      r_hold <= '0;
      r_ptr <= '0;
      r_grant <= '0;
      r_cnt <= '0;
      r_busy <= 1'b0;
      r_err <= 1'b0;
`ifdef UART_ARB_TAG_EN
      r_tag_id <= '0;
      r_tag_vld <= 1'b0;
`endif
    end else begin
      r_state <= w_nxt;
      r_ready <= w_ready;
      r_start <= w_start;
      r_data <= w_data;
      r_hold <= w_hold;
      r_ptr <= w_ptr;
      r_grant <= w_grant;
      r_cnt <= w_cnt;
      r_busy <= (w_nxt != S_IDLE);
      r_err <= w_err;
`ifdef UART_ARB_TAG_EN
      r_tag_id <= w_tag_id;
      r_tag_vld <= w_tag_vld;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter with a simple UART core model.
// Expected tag bytes are added when UART_ARB_TAG_EN is defined.
module tb_uart_tx_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, tx_busy, tx_start, busy, err_timeout;
  logic [3:0] req_valid = '0, req_ready, clr = '0;
  logic [31:0] req_data = '0;
  logic [7:0] tx_data;
  logic [1:0] grant_id;
  typedef struct {logic [7:0] d; logic [1:0] g;} exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_fail = 0, starts = 0, pushed = 0, last_tag = -1, core_hi = 5;
  bit core_en = 1'b1;
  uart_tx_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout)
  );
  always #5 clk = ~clk;
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction
  function automatic void push(int id, logic [7:0] d);
    sb.push_back('{d, 2'(id)});
    pushed++;
  endfunction
  // ok=0 marks a transfer whose first byte on the wire times out
  function automatic void exp_byte(int id, logic [7:0] d, bit ok);
`ifdef UART_ARB_TAG_EN
    if (last_tag != id) begin
      push(id, 8'hF0 | 8'(id));
      if (!ok) return;
      last_tag = id;
    end
`endif
    push(id, d);
  endfunction
  task automatic send(int id, logic [7:0] d, bit ok = 1'b1);
    exp_byte(id, d, ok);
    req_data[8*id +: 8] = d;
    req_valid[id] = 1'b1;
  endtask
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      if (clr[i]) begin
        req_valid[i] = 1'b0;
        clr[i] = 1'b0;
      end else if (req_ready[i] && req_valid[i]) clr[i] = 1'b1;
  endtask
  task automatic wait_done(string nm);
    int t = 0;
    while ((busy || req_valid != 0 || sb.size() != 0) && t < 2000) begin tick(); t++; end
    chk(nm, t < 2000, 1);
  endtask
  task automatic wait_empty(string nm);
    int t = 0;
    while (sb.size() != 0 && t < 300) begin tick(); t++; end
    chk(nm, t < 300, 1);
  endtask
  task automatic wait_busy(logic lvl, string nm);
    int t = 0;
    while (tx_busy !== lvl && t < 300) begin tick(); t++; end
    chk(nm, t < 300, 1);
  endtask
  task automatic chk_zero(string p);
    chk({p, "_ready"}, req_ready, 0);
    chk({p, "_start"}, tx_start, 0);
    chk({p, "_data"}, tx_data, 0);
    chk({p, "_grant"}, grant_id, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_err"}, err_timeout, 0);
  endtask
  // core model: busy rises two cycles after start and aborts on reset
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_start && core_en) begin
        for (int j = 0; j < 2 && rst_n; j++) begin @(posedge clk); #1; end
        if (rst_n) tx_busy = 1'b1;
        for (int j = 0; j < core_hi && rst_n; j++) begin @(posedge clk); #1; end
        tx_busy = 1'b0;
      end
    end
  end
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      chk("ready_onehot0", $onehot0(req_ready), 1);
      if (tx_start === 1'b1) begin
        starts++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_start: got data %0h grant %0d expected none", tx_data, grant_id);
        end else begin
          e = sb.pop_front();
          chk("tx_data", tx_data, e.d);
          chk("tx_grant", grant_id, e.g);
        end
      end
    end
  end
  initial begin
    int t, s0, p0;
    tick();
    tick();
    chk_zero("rst");
    rst_n = 1'b1;
    tick();
    core_hi = 100;
    send(0, 8'h60);
    tick();
    chk("t1_ready", req_ready, 4'b0001);
    tick();
    chk("t1_start", tx_start, 1);
    wait_empty("t1_sent");
    wait_busy(1'b1, "t1_busy_hi");
    wait_busy(1'b0, "t1_busy_lo");
    chk("t1_busy_hold", busy, 1);
    tick();
    chk("t1_busy_drop", busy, 0);
    chk("t1_err", err_timeout, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    last_tag = -1;
    core_hi = 5;
    s0 = starts;
    p0 = pushed;
    for (int i = 0; i < 4; i++) send(i, 8'hA0 + 8'(i));
    wait_done("t2_done");
    chk("t2_starts", starts - s0, pushed - p0);
    send(2, 8'h22);
    wait_done("t3_pre");
    send(1, 8'h51);
    send(2, 8'h52);
    wait_done("t3_done");
    core_en = 1'b0;
    send(0, 8'h77, 1'b0);
    t = 0;
    while (!tx_start && t < 20) begin tick(); t++; end
    chk("t4_start_seen", tx_start, 1);
    t = 0;
    while (!err_timeout && t < 200) begin tick(); t++; end
    chk("t4_to_cycles", t, 65);
    chk("t4_idle", busy, 0);
    core_en = 1'b1;
    send(1, 8'h78);
    wait_done("t4_next");
    chk("t4_err_sticky", err_timeout, 1);
    core_hi = 20;
    send(0, 8'h33);
    wait_empty("t5_sent");
    wait_busy(1'b1, "t5_busy_hi");
    tick();
    tick();
    req_data[7:0] = 8'h34;
    req_data[23:16] = 8'h35;
    req_valid[0] = 1'b1;
    req_valid[2] = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    chk_zero("t5_rst");
    rst_n = 1'b1;
    last_tag = -1;
    exp_byte(0, 8'h34, 1'b1);
    exp_byte(2, 8'h35, 1'b1);
    wait_done("t5_done");
    core_hi = 5;
    send(1, 8'h41);
    wait_done("t6_a");
    send(1, 8'h42);
    wait_done("t6_b");
    send(3, 8'h43);
    wait_done("t6_c");
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
